// File: rtl/tn8008_io_pkg.sv
// tn8008_io_pkg: shared 8008 I/O encodings (ingress states, CSR bits, I/O addresses)
package tn8008_io_pkg;
  typedef enum logic {S_IDLE, S_ACK} rx_state_e;
  localparam int RX_READY = 0;
  localparam int TX_READY = 2;
  localparam int RX_OVF = 7;
  localparam logic [7:0] IO_ADDR_CSR = 8'h00;
  localparam logic [7:0] IO_ADDR_RX = 8'h01;
  localparam logic [7:0] IO_ADDR_TX = 8'h10;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: uart_rx handshake plus CPU-side read/status signals of the RX buffer
interface uart_rx_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic [7:0] rx_data;
  logic rx_data_ready;
  logic rx_clear;
  logic pop;
  logic ovf_clear;
  logic [7:0] out_data;
  logic out_ready;
  logic overflow;
  logic [DEPTH_LOG2:0] count;
  logic rts_n;
  modport master (
    output rx_data, rx_data_ready, pop, ovf_clear,
    input rx_clear, out_data, out_ready, overflow, count, rts_n
  );
  modport slave (
    input rx_data, rx_data_ready, pop, ovf_clear,
    output rx_clear, out_data, out_ready, overflow, count, rts_n
  );
endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// byte_fifo: flop-array FIFO; full/empty from count, pop-then-push when full
module byte_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(2**AW);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rptr_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= do_pop ? rptr_q + 1'b1 : rptr_q;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: uart_rx ingress handshake + FIFO + pop edge detect; RTS hysteresis under UART_RX_FIFO_RTS_EN
module uart_rx_fifo
  import tn8008_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int HIGH_WATER = 12,
  parameter int LOW_WATER = 4
) (
  input logic sys_clk,
  input logic reset,
  uart_rx_fifo_if.slave bus
);
  if (LOW_WATER >= HIGH_WATER) begin : g_bad_water
    $error("LOW_WATER must be below HIGH_WATER");
  end
  rx_state_e state_q, state_d;
  logic pop_d_q, ovf_q, ovf_d, push, pop_ev, full, empty;
  logic [DEPTH_LOG2:0] count;
  always_comb begin
    state_d = state_q;
    state_d = bus.rx_data_ready ? S_ACK : S_IDLE;
  end
  assign push = (state_q == S_IDLE) & bus.rx_data_ready;
  assign pop_ev = bus.pop & ~pop_d_q;
  // A pop in the same cycle frees the slot, so only a pop-less push into full drops
  assign ovf_d = (push & full & ~pop_ev) | (ovf_q & ~bus.ovf_clear);
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pop_d_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_d_q <= bus.pop;
      ovf_q <= ovf_d;
    end
  end
  byte_fifo #(.DW(8), .AW(DEPTH_LOG2)) u_fifo (
    .clk(sys_clk),
    .rst(reset),
    .push(push),
    .pop(pop_ev),
    .wdata(bus.rx_data),
    .rdata(bus.out_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.rx_clear = state_q == S_ACK;
  assign bus.out_ready = ~empty;
  assign bus.overflow = ovf_q;
  assign bus.count = count;
`ifdef UART_RX_FIFO_RTS_EN
  logic rts_q, rts_d;
  assign rts_d = (count >= (DEPTH_LOG2+1)'(HIGH_WATER)) ? 1'b1 :
                 (count <= (DEPTH_LOG2+1)'(LOW_WATER)) ? 1'b0 : rts_q;
  always_ff @(posedge sys_clk)
    rts_q <= reset ? 1'b0 : rts_d;
  assign bus.rts_n = rts_q;
`else
  assign bus.rts_n = 1'b0;
`endif
endmodule
